int_frame_loader: RTL and testbench

//  Upstream feeder of the PE_BLOCK array. Accepts a stream of channel LLR samples over a

---
 rtl/ldpc_pkg.sv | 18 +
 rtl/llr_saturate.sv | 31 +++
 rtl/int_frame_loader.sv | 122 ++++++++++++
 tb/tb_int_frame_loader.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ldpc_pkg.sv
// Shared types and defaults for the LDPC decoder front end.
package ldpc_pkg;

    localparam int MESSAGE_WIDTH_DEF = 5;
    localparam int ADDR_WIDTH_DEF    = 5;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WAIT_SWAP
    } loader_state_t;

    // Largest magnitude of a symmetric signed message of the given width.
    function automatic int msg_max(input int width);
        return (1 << (width - 1)) - 1;
    endfunction

endpackage

// File: rtl/llr_saturate.sv
// Scales a raw channel LLR by an arithmetic right shift and clamps it symmetrically
// into the intrinsic message width (the most negative code is never produced).
module llr_saturate
    import ldpc_pkg::*;
#(
    parameter int IN_WIDTH      = 8,
    parameter int MESSAGE_WIDTH = MESSAGE_WIDTH_DEF,
    parameter int FRAC_SHIFT    = 2
) (
    input  logic signed [IN_WIDTH-1:0]      in_data,
    output logic        [MESSAGE_WIDTH-1:0] sat_data
);

    localparam logic signed [IN_WIDTH-1:0] SAT_POS = IN_WIDTH'(msg_max(MESSAGE_WIDTH));
    localparam logic signed [IN_WIDTH-1:0] SAT_NEG = -SAT_POS;

    logic signed [IN_WIDTH-1:0] shifted;
    logic signed [IN_WIDTH-1:0] clamped;

    always_comb begin
        shifted = in_data >>> FRAC_SHIFT;
        clamped = shifted;
        if (shifted > SAT_POS) begin
            clamped = SAT_POS;
        end else if (shifted < SAT_NEG) begin
            clamped = SAT_NEG;
        end
        sat_data = clamped[MESSAGE_WIDTH-1:0];
    end

endmodule

// File: rtl/int_frame_loader.sv
// Streams channel LLRs into the idle intrinsic bank of the PE column chain,
// PE-major / address-minor, then stalls until the decoder swaps frames.
module int_frame_loader
    import ldpc_pkg::*;
#(
    parameter int L             = 32,
    parameter int N_PE          = 4,
    parameter int ADDR_WIDTH    = ADDR_WIDTH_DEF,
    parameter int IN_WIDTH      = 8,
    parameter int MESSAGE_WIDTH = MESSAGE_WIDTH_DEF,
    parameter int FRAC_SHIFT    = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic signed [IN_WIDTH-1:0] in_data,
    input  logic                       f_id,
    output logic [ADDR_WIDTH-1:0]      load_add,
    output logic [MESSAGE_WIDTH-1:0]   int_out,
    output logic [N_PE-1:0]            pe_select,
    output logic                       frame_done,
    output logic                       overrun
);

    localparam int PE_W = (N_PE > 1) ? $clog2(N_PE) : 1;
    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(L - 1);
    localparam logic [PE_W-1:0]       PE_LAST   = PE_W'(N_PE - 1);

    loader_state_t           state;
    logic [ADDR_WIDTH-1:0]   addr_cnt;
    logic [PE_W-1:0]         pe_cnt;
    logic                    fid_q;
    logic                    fid_init;
    logic [MESSAGE_WIDTH-1:0] sat_data;
    logic                    accept;
    logic                    fid_toggle;
    logic                    last_sample;
    logic                    cnt_nonzero;

    llr_saturate #(
        .IN_WIDTH      (IN_WIDTH),
        .MESSAGE_WIDTH (MESSAGE_WIDTH),
        .FRAC_SHIFT    (FRAC_SHIFT)
    ) u_sat (
        .in_data  (in_data),
        .sat_data (sat_data)
    );

    assign in_ready    = (state == LOAD);
    assign accept      = in_valid & in_ready;
    // fid_q is only meaningful once it has captured f_id after reset release.
    assign fid_toggle  = fid_init & (f_id != fid_q);
    assign last_sample = (addr_cnt == ADDR_LAST) && (pe_cnt == PE_LAST);
    assign cnt_nonzero = (addr_cnt != '0) || (pe_cnt != '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            addr_cnt   <= '0;
            pe_cnt     <= '0;
            fid_q      <= 1'b0;
            fid_init   <= 1'b0;
            load_add   <= '0;
            int_out    <= '0;
            pe_select  <= '0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            pe_select  <= '0;
            frame_done <= 1'b0;
            if (!fid_init) begin
                fid_init <= 1'b1;
                fid_q    <= f_id;
            end
            if (!enable) begin
                state    <= IDLE;
                addr_cnt <= '0;
                pe_cnt   <= '0;
            end else begin
                case (state)
                    IDLE: state <= LOAD;
                    LOAD: begin
                        // A swap arriving with the final accept is a clean hand-off, not an overrun.
                        if (fid_toggle) begin
                            fid_q <= f_id;
                            if (cnt_nonzero && !(accept && last_sample)) begin
                                overrun <= 1'b1;
                            end
                        end
                        if (accept) begin
                            load_add  <= addr_cnt;
                            int_out   <= sat_data;
                            pe_select <= N_PE'(1) << pe_cnt;
                            if (addr_cnt == ADDR_LAST) begin
                                addr_cnt <= '0;
                                if (pe_cnt == PE_LAST) begin
                                    pe_cnt     <= '0;
                                    frame_done <= 1'b1;
                                    state      <= WAIT_SWAP;
                                end else begin
                                    pe_cnt <= pe_cnt + PE_W'(1);
                                end
                            end else begin
                                addr_cnt <= addr_cnt + ADDR_WIDTH'(1);
                            end
                        end
                    end
                    WAIT_SWAP: begin
                        if (fid_toggle) begin
                            fid_q <= f_id;
                            state <= LOAD;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_int_frame_loader.sv
// Bench for int_frame_loader: directed sequences, a saturation vector table and a
// randomized run, all checked against a sample-index reference model.
module tb_int_frame_loader;

    localparam int L     = 32;
    localparam int N_PE  = 4;
    localparam int AW    = 5;
    localparam int IW    = 8;
    localparam int MW    = 5;
    localparam int FS    = 2;
    localparam int FRAME = L * N_PE;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 enable;
    logic                 in_valid;
    logic                 in_ready;
    logic signed [IW-1:0] in_data;
    logic                 f_id;
    logic [AW-1:0]        load_add;
    logic [MW-1:0]        int_out;
    logic [N_PE-1:0]      pe_select;
    logic                 frame_done;
    logic                 overrun;

    int passed = 0;
    int total  = 0;

    // reference model: a linear sample index k within the frame
    bit m_loading, m_waiting, m_started, m_fid, m_over, m_done;
    int k, e_addr, e_int, e_sel;

    typedef struct {
        logic signed [IW-1:0] din;
        logic [MW-1:0]        dout;
    } sat_vec_t;

    sat_vec_t tbl[8];

    always #5 clk = ~clk;

    int_frame_loader #(
        .L             (L),
        .N_PE          (N_PE),
        .ADDR_WIDTH    (AW),
        .IN_WIDTH      (IW),
        .MESSAGE_WIDTH (MW),
        .FRAC_SHIFT    (FS)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .f_id       (f_id),
        .load_add   (load_add),
        .int_out    (int_out),
        .pe_select  (pe_select),
        .frame_done (frame_done),
        .overrun    (overrun)
    );

    task automatic chk(input string name, input int act, input int exp_v);
        total++;
        if (act == exp_v) passed++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp_v, $time);
    endtask

    // floor(d / 2**FS), then symmetric clamp, returned as an MW-bit pattern
    function automatic int sat_ref(input int d);
        int div, v, lim;
        div = 1 << FS;
        lim = (1 << (MW - 1)) - 1;
        v = (d >= 0) ? d / div : -((-d + div - 1) / div);
        if (v > lim)  v = lim;
        if (v < -lim) v = -lim;
        return v & ((1 << MW) - 1);
    endfunction

    task automatic model_reset();
        m_loading = 0; m_waiting = 0; m_started = 0; m_fid = 0;
        m_over = 0; m_done = 0;
        k = 0; e_addr = 0; e_int = 0; e_sel = 0;
    endtask

    task automatic step();
        bit acc, tog;
        e_sel  = 0;
        m_done = 0;
        if (reset) begin
            acc = in_valid && m_loading;
            tog = m_started && (f_id != m_fid);
            if (!m_started) begin
                m_started = 1;
                m_fid     = f_id;
            end
            if (!enable) begin
                m_loading = 0; m_waiting = 0; k = 0;
            end else if (m_loading) begin
                if (tog) begin
                    m_fid = f_id;
                    if (k != 0 && !(acc && k == FRAME - 1)) m_over = 1;
                end
                if (acc) begin
                    e_addr = k % L;
                    e_sel  = 1 << (k / L);
                    e_int  = sat_ref(int'(in_data));
                    k++;
                    if (k == FRAME) begin
                        k = 0; m_done = 1; m_loading = 0; m_waiting = 1;
                    end
                end
            end else if (m_waiting) begin
                if (tog) begin
                    m_fid = f_id; m_waiting = 0; m_loading = 1;
                end
            end else begin
                m_loading = 1;
            end
        end
        @(posedge clk);
        #1;
        chk("in_ready",   in_ready,   m_loading);
        chk("pe_select",  pe_select,  e_sel);
        chk("load_add",   load_add,   e_addr);
        chk("int_out",    int_out,    e_int);
        chk("frame_done", frame_done, m_done);
        chk("overrun",    overrun,    m_over);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_in_ready"},   in_ready,   0);
        chk({tag, "_pe_select"},  pe_select,  0);
        chk({tag, "_load_add"},   load_add,   0);
        chk({tag, "_int_out"},    int_out,    0);
        chk({tag, "_frame_done"}, frame_done, 0);
        chk({tag, "_overrun"},    overrun,    0);
    endtask

    initial begin
        int activity, prev_addr;

        tbl[0] = '{din: 8'sd100,  dout: 5'd15};
        tbl[1] = '{din: -8'sd128, dout: 5'b10001};
        tbl[2] = '{din: 8'sd20,   dout: 5'd5};
        tbl[3] = '{din: -8'sd3,   dout: 5'b11111};
        tbl[4] = '{din: 8'sd63,   dout: 5'd15};
        tbl[5] = '{din: 8'sd60,   dout: 5'd15};
        tbl[6] = '{din: -8'sd60,  dout: 5'b10001};
        tbl[7] = '{din: 8'sd3,    dout: 5'd0};

        // reset held with valid high: everything quiet
        model_reset();
        reset = 1'b0; enable = 1'b0; in_valid = 1'b1; in_data = 8'sd77; f_id = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("rst");
        reset = 1'b1; enable = 1'b1; in_valid = 1'b0;
        step();
        chk("ready_after_enable", in_ready, 1);

        // full frame, value k, no gaps
        for (int i = 0; i < FRAME; i++) begin
            in_valid = 1'b1;
            in_data  = IW'(i);
            step();
            if (i == 40) begin
                chk("s40_pe_select", pe_select, 2);
                chk("s40_load_add",  load_add,  8);
                chk("s40_int_out",   int_out,   10);
            end
            chk("frame_done_only_last", frame_done, (i == FRAME - 1) ? 1 : 0);
        end
        chk("ready_after_frame", in_ready, 0);

        // stalled until f_id toggles
        activity = 0;
        in_data  = 8'sd50;
        repeat (50) begin
            step();
            if (pe_select != '0) activity++;
        end
        chk("wait_swap_activity", activity, 0);
        f_id = 1'b1;
        step();
        chk("ready_after_swap", in_ready, 1);
        in_data = 8'sd0;
        step();
        chk("swap_pe0",   pe_select, 1);
        chk("swap_addr0", load_add,  0);

        // saturation vectors
        for (int i = 0; i < 8; i++) begin
            in_data = tbl[i].din;
            step();
            chk($sformatf("sat_tbl[%0d]", i), int_out, tbl[i].dout);
        end

        // input gap mid-frame, then an early swap
        prev_addr = int'(load_add);
        in_valid  = 1'b0;
        repeat (3) begin
            step();
            chk("gap_pe_zero", pe_select, 0);
        end
        in_valid = 1'b1;
        in_data  = 8'sd4;
        step();
        chk("gap_no_skip", load_add, prev_addr + 1);
        chk("toggle_at_sample10", k, 10);
        f_id    = 1'b0;
        in_data = 8'sd5;
        step();
        chk("overrun_set", overrun, 1);
        repeat (5) begin
            in_data = IW'($urandom);
            step();
        end
        chk("overrun_sticky", overrun, 1);

        // disable at sample 70
        for (int n = 0; n < 200 && k < 70; n++) begin
            in_data = IW'($urandom);
            step();
        end
        enable   = 1'b0;
        in_valid = 1'b0;
        step();
        chk("disable_pe_zero", pe_select, 0);
        chk("disable_ready",   in_ready,  0);
        enable = 1'b1;
        step();
        in_valid = 1'b1;
        in_data  = 8'sd9;
        step();
        chk("reenable_pe0",   pe_select, 1);
        chk("reenable_addr0", load_add,  0);

        // asynchronous reset mid-frame
        repeat (20) begin
            in_data = IW'($urandom);
            step();
        end
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        chk_all_zero("async_rst");
        @(posedge clk);
        #1;
        reset    = 1'b1;
        in_valid = 1'b0;
        step();
        in_valid = 1'b1;
        in_data  = 8'sd33;
        step();
        chk("rst_restart_pe0",   pe_select, 1);
        chk("rst_restart_addr0", load_add,  0);
        chk("rst_overrun_clear", overrun,   0);

        // randomized traffic
        for (int n = 0; n < 2000; n++) begin
            enable   = ($urandom_range(0, 199) != 0);
            in_valid = ($urandom_range(0, 9) < 7);
            in_data  = IW'($urandom);
            if ($urandom_range(0, 99) < 2) f_id = ~f_id;
            step();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
